alu_mdu: RTL and testbench

Parametrised execute-stage arithmetic unit for the pipelined CPU. It registers every result and adds an iterative multiply/divide engine with HI/LO registers. A start/busy/done handshake lets the hazard unit stall the pipeline while a multi-cycle operation runs. All single-cycle ALU encodings are kept, and two move-from-HI/LO operations are added.

---
 rtl/alu_mdu.sv | 177 +++++++++++++++++
 tb/tb_alu_mdu.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mdu.sv
// alu_mdu: registered execute-stage ALU with an iterative multiply/divide
// engine and HI/LO registers. Single-cycle ops finish in one clock; multu/divu
// iterate WIDTH steps while busy is high, then write res/equ/hi/lo together.
module alu_mdu #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [3:0]         aluop,
   input  logic [WIDTH-1:0]   x,
   input  logic [WIDTH-1:0]   y,
   input  logic [SHAMT_W-1:0] shamt,
   output logic [WIDTH-1:0]   res,
   output logic               equ,
   output logic               busy,
   output logic               done,
   output logic [WIDTH-1:0]   hi,
   output logic [WIDTH-1:0]   lo
);

   localparam logic [3:0] OP_SLL   = 4'd0;
   localparam logic [3:0] OP_SRA   = 4'd1;
   localparam logic [3:0] OP_SRL   = 4'd2;
   localparam logic [3:0] OP_MULTU = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_ADD   = 4'd5;
   localparam logic [3:0] OP_SUB   = 4'd6;
   localparam logic [3:0] OP_AND   = 4'd7;
   localparam logic [3:0] OP_OR    = 4'd8;
   localparam logic [3:0] OP_XOR   = 4'd9;
   localparam logic [3:0] OP_NOR   = 4'd10;
   localparam logic [3:0] OP_SLT   = 4'd11;
   localparam logic [3:0] OP_SLTU  = 4'd12;
   localparam logic [3:0] OP_MFHI  = 4'd13;
   localparam logic [3:0] OP_MFLO  = 4'd14;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2
   } state_t;

   state_t               state, state_n;
   logic [SHAMT_W-1:0]   cnt;       // steps remaining, WIDTH-1 down to 0
   logic [WIDTH-1:0]     opx;       // latched multiplicand
   logic [WIDTH-1:0]     opy;       // latched multiplier (shifts right) / divisor
   logic [2*WIDTH-1:0]   acc;       // mul: partial product; div: {remainder, dividend/quotient}
   logic                 eq_lat;    // x == y captured when the mul/div was accepted
   logic                 last;
   logic [WIDTH-1:0]     alu_res;
   logic [WIDTH:0]       mul_sum;
   logic [2*WIDTH-1:0]   mul_next;
   logic [WIDTH:0]       div_shift;
   logic [WIDTH:0]       div_diff;
   logic                 div_ok;
   logic [2*WIDTH-1:0]   div_next;

   assign busy = (state != IDLE);
   assign last = (cnt == '0);

   // State register for the IDLE/MUL/DIV sequencer.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   // Next-state logic: mul/div leave IDLE, and return on the step where cnt reaches 0.
   always_comb begin
      state_n = state;
      case (state)
         IDLE: if (start) begin
            if (aluop == OP_MULTU)     state_n = MUL;
            else if (aluop == OP_DIVU) state_n = DIV;
         end
         MUL, DIV: if (last) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Single-cycle result; mfhi/mflo see HI/LO as they stand at the accepting edge.
   always_comb begin
      // NOTE: default first so no opcode leaves alu_res unassigned, which would infer a latch.
      alu_res = '0;
      case (aluop)
         OP_SLL:  alu_res = y << shamt;
         OP_SRA:  alu_res = $signed(y) >>> shamt;
         OP_SRL:  alu_res = y >> shamt;
         OP_ADD:  alu_res = x + y;
         OP_SUB:  alu_res = x - y;
         OP_AND:  alu_res = x & y;
         OP_OR:   alu_res = x | y;
         OP_XOR:  alu_res = x ^ y;
         OP_NOR:  alu_res = ~(x | y);
         OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(x) < $signed(y))};
         OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (x < y)};
         OP_MFHI: alu_res = hi;
         OP_MFLO: alu_res = lo;
         default: alu_res = '0;
      endcase
   end

   // One shift-add step (LSB of multiplier) and one restoring shift-subtract step.
   always_comb begin
      mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (opy[0] ? {1'b0, opx} : {(WIDTH+1){1'b0}});
      mul_next  = {mul_sum, acc[WIDTH-1:1]};
      // Bring the next dividend bit into the remainder; the top bit of the
      // difference is the borrow, i.e. remainder < divisor.
      div_shift = acc[2*WIDTH-1:WIDTH-1];
      div_diff  = div_shift - {1'b0, opy};
      div_ok    = ~div_diff[WIDTH];
      div_next  = {(div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                   acc[WIDTH-2:0], div_ok};
   end

   // Datapath: accept ops in IDLE, iterate mul/div, write results on the done edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt    <= '0;
         opx    <= '0;
         opy    <= '0;
         acc    <= '0;
         eq_lat <= 1'b0;
         res    <= '0;
         equ    <= 1'b0;
         done   <= 1'b0;
         hi     <= '0;
         lo     <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: if (start) begin
               if (aluop == OP_MULTU || aluop == OP_DIVU) begin
                  cnt    <= SHAMT_W'(WIDTH-1);
                  opx    <= x;
                  opy    <= y;
                  eq_lat <= (x == y);
                  acc    <= (aluop == OP_DIVU) ? {{WIDTH{1'b0}}, x} : '0;
               end else begin
                  res  <= alu_res;
                  equ  <= (x == y);
                  done <= 1'b1;
               end
            end
            MUL: begin
               acc <= mul_next;
               opy <= opy >> 1;
               if (last) begin
                  hi   <= mul_next[2*WIDTH-1:WIDTH];
                  lo   <= mul_next[WIDTH-1:0];
                  res  <= mul_next[WIDTH-1:0];
                  equ  <= eq_lat;
                  done <= 1'b1;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            DIV: begin
               acc <= div_next;
               if (last) begin
                  hi   <= div_next[2*WIDTH-1:WIDTH];
                  lo   <= div_next[WIDTH-1:0];
                  res  <= div_next[WIDTH-1:0];
                  equ  <= eq_lat;
                  done <= 1'b1;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_mdu.sv
// Self-checking bench for alu_mdu: a 32-bit and an 8-bit instance, directed
// cases plus random operations compared with an arithmetic reference model.
module tb_alu_mdu;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        start32;
   logic [3:0]  aluop32;
   logic [31:0] x32, y32, res32, hi32, lo32;
   logic [4:0]  sh32;
   logic        equ32, busy32, done32;

   logic        start8;
   logic [3:0]  aluop8;
   logic [7:0]  x8, y8, res8, hi8, lo8;
   logic [2:0]  sh8;
   logic        equ8, busy8, done8;

   alu_mdu #(.WIDTH(32), .SHAMT_W(5)) dut32 (
      .clk(clk), .rst(rst), .start(start32), .aluop(aluop32), .x(x32), .y(y32),
      .shamt(sh32), .res(res32), .equ(equ32), .busy(busy32), .done(done32),
      .hi(hi32), .lo(lo32)
   );

   alu_mdu #(.WIDTH(8), .SHAMT_W(3)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .aluop(aluop8), .x(x8), .y(y8),
      .shamt(sh8), .res(res8), .equ(equ8), .busy(busy8), .done(done8),
      .hi(hi8), .lo(lo8)
   );

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] hm32, lm32, hm8, lm8;   // model HI/LO per instance
   logic [31:0] last_res32;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] o_res(input int w);
      return (w == 32) ? res32 : {24'b0, res8};
   endfunction
   function automatic logic [31:0] o_hi(input int w);
      return (w == 32) ? hi32 : {24'b0, hi8};
   endfunction
   function automatic logic [31:0] o_lo(input int w);
      return (w == 32) ? lo32 : {24'b0, lo8};
   endfunction
   function automatic logic o_equ(input int w);
      return (w == 32) ? equ32 : equ8;
   endfunction
   function automatic logic o_busy(input int w);
      return (w == 32) ? busy32 : busy8;
   endfunction
   function automatic logic o_done(input int w);
      return (w == 32) ? done32 : done8;
   endfunction

   // Reference: plain arithmetic on the operation's definition.
   task automatic model(input int w, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int sh, inout logic [31:0] hm, inout logic [31:0] lm,
                        output logic [31:0] r);
      logic [31:0] mask;
      logic [63:0] p;
      longint      sa, sb;
      mask = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_00FF;
      r = '0;
      case (op)
         4'd0:  r = (b << sh) & mask;
         4'd1:  begin
                   r = b >> sh;
                   if (b[w-1]) r = r | (mask & ~(mask >> sh));
                end
         4'd2:  r = b >> sh;
         4'd3:  begin
                   p  = {32'b0, a} * {32'b0, b};
                   lm = p[31:0] & mask;
                   hm = 32'(p >> w) & mask;
                   r  = lm;
                end
         4'd4:  begin
                   if (b == 0) begin lm = mask; hm = a; end
                   else begin lm = a / b; hm = a % b; end
                   r = lm;
                end
         4'd5:  r = (a + b) & mask;
         4'd6:  r = (a - b) & mask;
         4'd7:  r = a & b;
         4'd8:  r = a | b;
         4'd9:  r = a ^ b;
         4'd10: r = ~(a | b) & mask;
         4'd11: begin
                   sa = a[w-1] ? longint'(a) - (longint'(1) << w) : longint'(a);
                   sb = b[w-1] ? longint'(b) - (longint'(1) << w) : longint'(b);
                   r  = (sa < sb) ? 32'd1 : 32'd0;
                end
         4'd12: r = (a < b) ? 32'd1 : 32'd0;
         4'd13: r = hm;
         4'd14: r = lm;
         default: r = '0;
      endcase
   endtask

   task automatic drive(input int w, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int sh, input logic st);
      if (w == 32) begin
         start32 = st; aluop32 = op; x32 = a; y32 = b; sh32 = sh[4:0];
      end else begin
         start8 = st; aluop8 = op; x8 = a[7:0]; y8 = b[7:0]; sh8 = sh[2:0];
      end
   endtask

   // Issue one operation, wait for completion within a bound, compare everything.
   task automatic do_op(input int w, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int sh);
      logic [31:0] er, hm, lm, mask;
      string       tag;
      int          cyc;
      mask = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_00FF;
      a  = a & mask;
      b  = b & mask;
      sh = sh % w;
      hm = (w == 32) ? hm32 : hm8;
      lm = (w == 32) ? lm32 : lm8;
      model(w, op, a, b, sh, hm, lm, er);
      tag = $sformatf("w%0d op%0d a=%0h b=%0h", w, op, a, b);
      @(negedge clk);
      drive(w, op, a, b, sh, 1'b1);
      @(negedge clk);
      drive(w, op, a, b, sh, 1'b0);
      if (op == 4'd3 || op == 4'd4) begin
         cyc = 0;
         while (o_busy(w) && cyc < 100) begin
            cyc++;
            @(negedge clk);
         end
         check({tag, " busy_cycles"}, 64'(cyc), 64'(w));
      end
      check({tag, " done"}, 64'(o_done(w)), 64'd1);
      check({tag, " busy"}, 64'(o_busy(w)), 64'd0);
      check({tag, " res"},  64'(o_res(w)),  64'(er));
      check({tag, " equ"},  64'(o_equ(w)),  64'(a == b));
      check({tag, " hi"},   64'(o_hi(w)),   64'(hm));
      check({tag, " lo"},   64'(o_lo(w)),   64'(lm));
      if (w == 32) begin hm32 = hm; lm32 = lm; last_res32 = er; end
      else         begin hm8  = hm; lm8  = lm; end
      if (op == 4'd3 || op == 4'd4) begin
         @(negedge clk);
         check({tag, " done_single_pulse"}, 64'(o_done(w)), 64'd0);
      end
   endtask

   initial begin
      logic [31:0] ra, rb, mask;
      int          wsel;
      rst = 1'b1;
      drive(32, 4'd0, 32'd0, 32'd0, 0, 1'b0);
      drive(8,  4'd0, 32'd0, 32'd0, 0, 1'b0);
      hm32 = '0; lm32 = '0; hm8 = '0; lm8 = '0; last_res32 = '0;
      repeat (2) @(negedge clk);
      check("reset res32",  64'(res32),  64'd0);
      check("reset equ32",  64'(equ32),  64'd0);
      check("reset busy32", 64'(busy32), 64'd0);
      check("reset done32", 64'(done32), 64'd0);
      check("reset hi32",   64'(hi32),   64'd0);
      check("reset lo32",   64'(lo32),   64'd0);
      check("reset res8",   64'(res8),   64'd0);
      check("reset hi8",    64'(hi8),    64'd0);
      check("reset lo8",    64'(lo8),    64'd0);
      rst = 1'b0;

      // Directed 32-bit cases.
      do_op(32, 4'd5,  32'hFFFF_FFFF, 32'd1, 0);
      check("add wrap literal", 64'(res32), 64'h0);
      do_op(32, 4'd1,  32'd0, 32'h8000_0000, 4);
      check("sra literal", 64'(res32), 64'hF800_0000);
      do_op(32, 4'd11, 32'hFFFF_FFFF, 32'd1, 0);
      do_op(32, 4'd12, 32'hFFFF_FFFF, 32'd1, 0);
      do_op(32, 4'd3,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      check("multu hi literal", 64'(hi32), 64'hFFFF_FFFE);
      do_op(32, 4'd13, 32'd0, 32'd0, 0);
      check("mfhi literal", 64'(res32), 64'hFFFF_FFFE);
      do_op(32, 4'd4,  32'd100, 32'd7, 0);
      check("divu lo literal", 64'(lo32), 64'd14);
      do_op(32, 4'd4,  32'd5, 32'd0, 0);
      check("divu0 lo literal", 64'(lo32), 64'hFFFF_FFFF);

      // Back-to-back single-cycle ops keep done high.
      @(negedge clk);
      drive(32, 4'd5, 32'd3, 32'd4, 0, 1'b1);
      @(negedge clk);
      drive(32, 4'd6, 32'd10, 32'd3, 0, 1'b1);
      check("b2b first done", 64'(done32), 64'd1);
      check("b2b first res",  64'(res32),  64'd7);
      @(negedge clk);
      drive(32, 4'd6, 32'd10, 32'd3, 0, 1'b0);
      check("b2b second done", 64'(done32), 64'd1);
      check("b2b second res",  64'(res32),  64'd7);
      @(negedge clk);
      check("b2b done drops", 64'(done32), 64'd0);
      last_res32 = 32'd7;

      // start while busy is ignored; reset mid-multiply aborts without writing HI/LO.
      @(negedge clk);
      drive(32, 4'd3, 32'h0001_2345, 32'h0000_0777, 0, 1'b1);
      @(negedge clk);
      drive(32, 4'd3, 32'h0001_2345, 32'h0000_0777, 0, 1'b0);
      repeat (4) @(negedge clk);
      drive(32, 4'd5, 32'd1, 32'd2, 0, 1'b1);
      @(negedge clk);
      drive(32, 4'd5, 32'd1, 32'd2, 0, 1'b0);
      check("busy ignores start busy", 64'(busy32), 64'd1);
      check("busy ignores start done", 64'(done32), 64'd0);
      check("busy ignores start res",  64'(res32),  64'(last_res32));
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #1;
      check("midop rst res",  64'(res32),  64'd0);
      check("midop rst equ",  64'(equ32),  64'd0);
      check("midop rst busy", 64'(busy32), 64'd0);
      check("midop rst done", 64'(done32), 64'd0);
      check("midop rst hi",   64'(hi32),   64'd0);
      check("midop rst lo",   64'(lo32),   64'd0);
      @(negedge clk);
      rst = 1'b0;
      hm32 = '0; lm32 = '0; hm8 = '0; lm8 = '0; last_res32 = '0;
      repeat (40) @(negedge clk);
      check("aborted mul no done", 64'(done32), 64'd0);
      check("aborted mul hi",      64'(hi32),   64'd0);
      check("aborted mul lo",      64'(lo32),   64'd0);
      do_op(32, 4'd4, 32'd1000, 32'd33, 0);

      // Directed 8-bit cases.
      do_op(8, 4'd3, 32'hFF, 32'hFF, 0);
      check("w8 multu hi literal", 64'(hi8), 64'hFE);
      do_op(8, 4'd4, 32'd200, 32'd9, 0);
      check("w8 divu lo literal", 64'(lo8), 64'd22);
      do_op(8, 4'd4, 32'd5, 32'd0, 0);
      do_op(8, 4'd1, 32'd0, 32'h90, 2);

      // Random operations on both widths, operands biased toward edge values.
      for (int k = 0; k < 120; k++) begin
         wsel = (k < 60) ? 32 : 8;
         mask = (wsel == 32) ? 32'hFFFF_FFFF : 32'h0000_00FF;
         case ($urandom_range(0, 3))
            0:       ra = $urandom;
            1:       ra = 32'd0;
            2:       ra = mask;
            default: ra = $urandom_range(0, 20);
         endcase
         case ($urandom_range(0, 3))
            0:       rb = $urandom;
            1:       rb = 32'd0;
            2:       rb = ($urandom_range(0, 1) != 0) ? ra : mask;
            default: rb = $urandom_range(0, 20);
         endcase
         do_op(wsel, 4'($urandom_range(0, 15)), ra, rb, int'($urandom_range(0, wsel - 1)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
